// File: rtl/sram_like_arbiter.sv
// Shares one sram-like bus between inst fetch and data memory: 1-cycle arbitration, one transaction in flight,
// losers held off with addr_ok=0 until idle. Define ARB_RR_EN for round-robin, otherwise data has fixed priority.
module sram_like_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } state_t;

  state_t state, state_nxt;
  logic   grant, grant_nxt;
  logic   last, last_nxt;
  logic   pick;
  logic   addr_hs;
  logic   data_hs;

`ifdef ARB_RR_EN
  // On a tie the requester that was not served last wins.
  assign pick = (inst_req && data_req) ? ~last : data_req;
`else
  assign pick = data_req;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      grant <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (inst_req || data_req) begin
          grant_nxt = pick;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (addr_hs) state_nxt = DATA;
      end
      DATA: begin
        if (bus_data_ok) begin
          last_nxt  = grant;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A granted requester that drops req mid-ADDR just parks the bus request low.
  assign bus_req = (state == ADDR) && (grant ? data_req : inst_req);
  assign addr_hs = bus_req && bus_addr_ok;
  assign data_hs = (state == DATA) && bus_data_ok;

  always_comb begin
    bus_wr    = 1'b0;
    bus_size  = '0;
    bus_addr  = '0;
    bus_wdata = '0;
    if (state == ADDR) begin
      if (grant) begin
        bus_wr    = data_wr;
        bus_size  = data_size;
        bus_addr  = data_addr;
        bus_wdata = data_wdata;
      end else begin
        bus_wr    = inst_wr;
        bus_size  = inst_size;
        bus_addr  = inst_addr;
        bus_wdata = inst_wdata;
      end
    end
  end

  assign inst_addr_ok = addr_hs && !grant;
  assign data_addr_ok = addr_hs && grant;
  assign inst_data_ok = data_hs && !grant;
  assign data_data_ok = data_hs && grant;
  assign inst_rdata   = inst_data_ok ? bus_rdata : '0;
  assign data_rdata   = data_data_ok ? bus_rdata : '0;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomised and directed bench: requester/slave models feed per-requester expected queues; a monitor
// checks arbitration order, handshake routing and read data against a transaction-level model.
module tb_sram_like_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_addr_ok, bus_data_ok, busy;
  logic        any_out;

  always #5 clk = ~clk;

  sram_like_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .busy(busy)
  );

  assign any_out = |{inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok, data_rdata,
                     bus_req, bus_wr, bus_size, bus_addr, bus_wdata, busy};

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave read data is a fixed function of the address, so responses prove the routing end to end.
  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a ^ 32'hDEAD_AEEF;
  endfunction

  function automatic logic pick(input logic i, input logic d, input logic lst);
`ifdef ARB_RR_EN
    return (i && d) ? ~lst : d;
`else
    return d;
`endif
  endfunction

  // Requester models (index 0 = inst, 1 = data) and slave model.
  logic        r_req [2];
  logic        r_wr [2];
  logic [1:0]  r_size [2];
  logic [31:0] r_addr [2];
  logic [31:0] r_wdata [2];
  int          r_todo [2];
  int          r_gap [2];
  bit          r_auto, r_hold;
  logic [31:0] q_inst [$];
  logic [31:0] q_dat [$];
  int          s_phase, s_cnt, s_dcnt, s_stall, s_data_dly;
  bit          s_rand, s_spur, s_hold;
  logic [31:0] s_rd;
  logic        n_resetn, n_bao, n_bdo;
  logic [31:0] n_brd;

  task automatic issue(input int s, input logic wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd);
    r_req[s] = 1'b1; r_wr[s] = wr; r_size[s] = sz; r_addr[s] = a; r_wdata[s] = wd;
    if (s == 0) q_inst.push_back(rd_of(a));
    else        q_dat.push_back(rd_of(a));
  endtask

  task automatic issue_rand(input int s);
    r_todo[s]--;
    issue(s, (s == 1) ? 1'($urandom_range(0, 1)) : 1'b0, 2'($urandom_range(0, 2)), $urandom, $urandom);
  endtask

  task automatic observe();
    for (int s = 0; s < 2; s++) begin
      logic ok;
      ok = (s == 0) ? inst_addr_ok : data_addr_ok;
      if (r_req[s] && ok) begin
        if (r_hold && r_todo[s] > 0) issue_rand(s);
        else begin
          r_req[s] = 1'b0;
          r_gap[s] = $urandom_range(0, 4);
        end
      end else if (!r_req[s] && r_auto && r_todo[s] > 0) begin
        if (r_gap[s] == 0) issue_rand(s);
        else r_gap[s]--;
      end
    end
    if (s_phase == 0) begin
      if (bus_req && bus_addr_ok) begin
        s_phase = 1;
        s_rd    = rd_of(bus_addr);
        s_dcnt  = s_rand ? $urandom_range(0, 2) : s_data_dly;
        s_cnt   = s_rand ? $urandom_range(0, 3) : s_stall;
      end else if (bus_req && s_cnt > 0) s_cnt--;
    end else if (bus_data_ok) s_phase = 0;
    else if (!s_hold && s_dcnt > 0) s_dcnt--;
    n_bao = (s_phase == 0) && (s_cnt == 0);
    n_bdo = (s_phase == 1 && s_dcnt == 0 && !s_hold) || (s_phase == 0 && s_spur && s_cnt != 0);
    n_brd = !n_bdo ? 32'h0 : ((s_phase == 1) ? s_rd : 32'hBAD0_BAD0);
  endtask

  task automatic step();
    @(negedge clk);
    resetn = n_resetn;
    inst_req = r_req[0]; inst_wr = r_wr[0]; inst_size = r_size[0]; inst_addr = r_addr[0]; inst_wdata = r_wdata[0];
    data_req = r_req[1]; data_wr = r_wr[1]; data_size = r_size[1]; data_addr = r_addr[1]; data_wdata = r_wdata[1];
    bus_addr_ok = n_bao; bus_data_ok = n_bdo; bus_rdata = n_brd;
    #1;
    observe();
  endtask

  task automatic clear_reqs();
    for (int s = 0; s < 2; s++) begin
      r_req[s] = 1'b0; r_todo[s] = 0; r_gap[s] = 0;
    end
    r_auto = 1'b0; r_hold = 1'b0;
    q_inst.delete(); q_dat.delete();
  endtask

  task automatic do_reset();
    n_resetn = 1'b0;
    clear_reqs();
    s_phase = 0; s_cnt = 0; s_stall = 0; s_data_dly = 0; s_rand = 0; s_spur = 0; s_hold = 0;
    n_bao = 1'b0; n_bdo = 1'b0; n_brd = '0;
    step(); step();
    chk("reset_outputs_in_reset", any_out, 1'b0);
    n_resetn = 1'b1;
    step();
    chk("reset_outputs_after", any_out, 1'b0);
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int c = 0;
    bit done = 0;
    while (!done && c < maxc) begin
      step();
      c++;
      done = q_inst.size() == 0 && q_dat.size() == 0 && !r_req[0] && !r_req[1] &&
             r_todo[0] == 0 && r_todo[1] == 0 && s_phase == 0 && !busy;
    end
    chk(name, done, 1'b1);
  endtask

  // Transaction-level monitor: bus free -> arbitration -> accept -> response.
  logic        m_free = 1'b1, m_win = 1'b0, m_last = 1'b1, m_acc = 1'b0;
  logic [1:0]  exp_ao, exp_do;

  initial forever begin
    @(negedge clk);
    #2;
    if (resetn !== 1'b1) begin
      m_free = 1'b1; m_last = 1'b1; m_acc = 1'b0;
    end else begin
      chk("busy", busy, !m_free);
      exp_ao = 2'b00;
      exp_do = 2'b00;
      if (m_free) begin
        if (inst_req || data_req) begin
          m_win = pick(inst_req, data_req, m_last);
          m_free = 1'b0;
          m_acc = 1'b0;
        end
      end else begin
        if (m_acc && bus_data_ok) exp_do = m_win ? 2'b01 : 2'b10;
        if (!m_acc && bus_addr_ok && (m_win ? data_req : inst_req)) exp_ao = m_win ? 2'b01 : 2'b10;
      end
      chk("addr_ok_routing", {inst_addr_ok, data_addr_ok}, exp_ao);
      chk("data_ok_routing", {inst_data_ok, data_data_ok}, exp_do);
      if (exp_ao != 2'b00) m_acc = 1'b1;
      if (exp_do != 2'b00) begin
        if (m_win == 1'b0) begin
          chk("inst_rsp_pending", q_inst.size() > 0, 1'b1);
          if (q_inst.size() > 0) chk("inst_rdata", inst_rdata, q_inst.pop_front());
        end else begin
          chk("data_rsp_pending", q_dat.size() > 0, 1'b1);
          if (q_dat.size() > 0) chk("data_rdata", data_rdata, q_dat.pop_front());
        end
        m_last = m_win;
        m_free = 1'b1;
      end
      if (!inst_data_ok) chk("inst_rdata_zero", inst_rdata, 32'h0);
      if (!data_data_ok) chk("data_rdata_zero", data_rdata, 32'h0);
    end
  end

  int order [$];
  int exp_order [4];
  int cyc;

  initial begin
    resetn = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
    for (int s = 0; s < 2; s++) begin
      r_wr[s] = 0; r_size[s] = 0; r_addr[s] = 0; r_wdata[s] = 0;
    end
    do_reset();

    // Single inst read with immediate slave.
    issue(0, 1'b0, 2'd2, 32'h0000_1000, 32'h0);
    step();
    chk("t1_arb_cycle", {inst_addr_ok, busy}, 2'b00);
    step();
    chk("t1_addr_ok", inst_addr_ok, 1'b1);
    chk("t1_bus_ctrl", {bus_req, bus_wr, bus_size}, 4'b1010);
    chk("t1_bus_addr", bus_addr, 32'h0000_1000);
    chk("t1_data_side_a", |{data_addr_ok, data_data_ok, data_rdata}, 1'b0);
    step();
    chk("t1_data_ok", inst_data_ok, 1'b1);
    chk("t1_rdata", inst_rdata, 32'hDEAD_BEEF);
    chk("t1_data_side_d", |{data_addr_ok, data_data_ok, data_rdata}, 1'b0);
    step();
    chk("t1_idle", busy, 1'b0);

    // Data write with a 3-cycle address stall.
    s_cnt = 3;
    issue(1, 1'b1, 2'd2, 32'h8000_0010, 32'h1234_5678);
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t2_ctrl_%0d", k), {bus_req, bus_wr, bus_size}, 4'b1110);
      chk($sformatf("t2_addr_%0d", k), bus_addr, 32'h8000_0010);
      chk($sformatf("t2_wdata_%0d", k), bus_wdata, 32'h1234_5678);
      chk($sformatf("t2_addr_ok_%0d", k), data_addr_ok, k == 3);
    end
    cyc = 0;
    do begin step(); cyc++; end while (!data_data_ok && cyc < 6);
    chk("t2_data_ok", data_data_ok, 1'b1);
    step();
    chk("t2_busy_drop", busy, 1'b0);

    // Simultaneous requests from reset, both held high for two transactions each.
    do_reset();
    r_hold = 1'b1;
    r_todo[0] = 2; r_todo[1] = 2;
    issue_rand(0);
    issue_rand(1);
`ifdef ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{1, 1, 0, 0};
`endif
    cyc = 0;
    while (order.size() < 4 && cyc < 100) begin
      step();
      if (inst_data_ok) order.push_back(0);
      if (data_data_ok) order.push_back(1);
      cyc++;
    end
    chk("t3_count", order.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < order.size()) chk($sformatf("t3_grant_%0d", i), order[i], exp_order[i]);
    r_hold = 1'b0;
    wait_idle(50, "t3_drain");

    // Spurious bus_data_ok in IDLE and ADDR.
    do_reset();
    s_cnt = 3;
    s_spur = 1'b1;
    step(); step();
    chk("t4_idle_spur", {inst_data_ok, data_data_ok, busy}, 3'b000);
    issue(1, 1'b0, 2'd1, 32'h0000_2222, 32'h0);
    step();
    chk("t4_arb_spur", data_data_ok, 1'b0);
    step();
    chk("t4_addr_spur_1", {data_data_ok, busy}, 2'b01);
    step();
    chk("t4_addr_spur_2", {data_data_ok, busy}, 2'b01);
    s_spur = 1'b0;
    wait_idle(30, "t4_done");

    // Reset in DATA with a late response after release.
    s_hold = 1'b1;
    issue(0, 1'b0, 2'd2, 32'h0000_3000, 32'h0);
    step(); step(); step();
    chk("t5_in_data", busy, 1'b1);
    n_resetn = 1'b0;
    clear_reqs();
    step();
    n_resetn = 1'b1;
    s_hold = 1'b0;
    step();
    chk("t5_after_release", busy, 1'b0);
    step();
    chk("t5_late_rsp_dropped", {inst_data_ok, data_data_ok, busy}, 3'b000);
    issue(1, 1'b0, 2'd2, 32'h0000_4444, 32'h0);
    wait_idle(30, "t5_new_txn");

    // Granted requester drops req for 2 ADDR cycles.
    s_cnt = 5;
    issue(0, 1'b0, 2'd0, 32'h0000_5001, 32'h0);
    step(); step();
    r_req[0] = 1'b0;
    step();
    chk("t6_drop_1", {bus_req, inst_addr_ok, busy}, 3'b001);
    step();
    chk("t6_drop_2", {bus_req, inst_addr_ok, busy}, 3'b001);
    r_req[0] = 1'b1;
    s_cnt = 0;
    step();
    chk("t6_reassert", {bus_req, busy}, 2'b11);
    chk("t6_reassert_addr", bus_addr, 32'h0000_5001);
    wait_idle(30, "t6_done");

    // Random traffic.
    do_reset();
    s_rand = 1'b1;
    r_auto = 1'b1;
    r_todo[0] = 25; r_todo[1] = 25;
    wait_idle(4000, "t7_random_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
